// File: rtl/ras_pkg.sv
// Shared types and sizing for the return-address-stack controller.
// Operation codes, controller states and default stack geometry.
package ras_pkg;

    localparam int RAS_DEPTH  = 16;
    localparam int RAS_DATA_W = 32;

    typedef enum logic {
        OP_RET  = 1'b0,
        OP_CALL = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_POP  = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/call_ret_unit_if.sv
// Request/response handshake between the processor control path and call_ret_unit.
interface call_ret_unit_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [DATA_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_addr;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, resp_ready,
        output req_ready, resp_valid, resp_addr, resp_err
    );
endinterface

// File: rtl/ras_occupancy.sv
// Shadow occupancy counter mirroring the stack fill level.
// Saturates at 0 and DEPTH; full/empty are registered alongside the count.
module ras_occupancy #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_nxt_s;

    // Next occupancy with saturation at both ends.
    always_comb begin
        count_nxt_s = count;
        if (inc && !dec && (count < CW'(DEPTH))) begin
            count_nxt_s = count + CW'(1);
        end else if (dec && !inc && (count != CW'(0))) begin
            count_nxt_s = count - CW'(1);
        end else begin
            count_nxt_s = count;
        end
    end

    // Occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CW'(0);
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt_s;
            full  <= (count_nxt_s == CW'(DEPTH));
            empty <= (count_nxt_s == CW'(0));
        end
    end

endmodule

// File: rtl/call_ret_unit.sv
// Turns CALL/RET requests into single-cycle push/pop strobes on the return-address
// stack and reports the result; overflow/underflow are rejected before the stack is touched.
module call_ret_unit
    import ras_pkg::*;
#(
    parameter int DATA_W = RAS_DATA_W,
    parameter int DEPTH  = RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    call_ret_unit_if.slave             bus,
    output logic                       stk_write_en,
    output logic                       stk_read_en,
    output logic [DATA_W-1:0]          stk_data_in,
    input  logic [DATA_W-1:0]          stk_data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    state_e            state_r;
    op_e               op_q;
    logic [DATA_W-1:0] addr_q;
    logic              err_q;
    logic              inc_s;
    logic              dec_s;

    // The counter moves on the edge that ends the strobe cycle, matching the stack pointer.
    assign inc_s        = (state_r == ST_PUSH);
    assign dec_s        = (state_r == ST_POP);
    assign bus.resp_err = err_q;

    ras_occupancy #(.DEPTH(DEPTH)) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_s),
        .dec   (dec_s),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Controller FSM with all handshake and strobe outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            op_q           <= OP_RET;
            addr_q         <= '0;
            err_q          <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_addr  <= '0;
            stk_write_en   <= 1'b0;
            stk_read_en    <= 1'b0;
            stk_data_in    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= op_e'(bus.req_op);
                        addr_q        <= bus.req_addr;
                        bus.req_ready <= 1'b0;
                        if ((bus.req_op == OP_CALL) && !full) begin
                            state_r      <= ST_PUSH;
                            stk_write_en <= 1'b1;
                            stk_data_in  <= bus.req_addr;
                        end else if ((bus.req_op == OP_RET) && !empty) begin
                            state_r     <= ST_POP;
                            stk_read_en <= 1'b1;
                        end else begin
                            state_r        <= ST_RESP;
                            err_q          <= 1'b1;
                            bus.resp_addr  <= '0;
                            bus.resp_valid <= 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    stk_write_en   <= 1'b0;
                    stk_data_in    <= '0;
                    err_q          <= 1'b0;
                    bus.resp_addr  <= (op_q == OP_CALL) ? addr_q : '0;
                    bus.resp_valid <= 1'b1;
                    state_r        <= ST_RESP;
                end
                ST_POP: begin
                    stk_read_en <= 1'b0;
                    state_r     <= ST_CAPT;
                end
                ST_CAPT: begin
                    // Stack read data is registered, so it is valid one cycle after the pop strobe.
                    bus.resp_addr  <= stk_data_out;
                    err_q          <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state_r        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    err_q          <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    stk_write_en   <= 1'b0;
                    stk_read_en    <= 1'b0;
                    stk_data_in    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_ret_unit.sv
// Self-checking bench for call_ret_unit: directed scenarios plus randomized CALL/RET traffic
// checked against a LIFO queue model, with a behavioural stack attached to the strobe port.
module tb_call_ret_unit;

    localparam int DW = 32;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stk_write_en;
    logic          stk_read_en;
    logic [DW-1:0] stk_data_in;
    logic [DW-1:0] stk_data_out = '0;
    logic [4:0]    count;
    logic          full;
    logic          empty;

    call_ret_unit_if #(.DATA_W(DW)) bus ();

    call_ret_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .stk_write_en (stk_write_en),
        .stk_read_en  (stk_read_en),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    // Behavioural 16-entry stack with registered read data and no pointer reset.
    logic [DW-1:0] stk_mem [DP];
    int            stk_sp = 0;
    logic          stk_clear = 1'b0;
    always @(posedge clk) begin
        if (stk_clear) begin
            stk_sp <= 0;
        end else if (stk_write_en && stk_sp < DP) begin
            stk_mem[stk_sp] <= stk_data_in;
            stk_sp          <= stk_sp + 1;
        end else if (stk_read_en && stk_sp > 0) begin
            stk_data_out <= stk_mem[stk_sp-1];
            stk_sp       <= stk_sp - 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    logic [DW-1:0] last_wr = '0;
    logic [DW-1:0] model_q [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: pulse counting and strobe exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stk_write_en) begin
                wr_pulses <= wr_pulses + 1;
                last_wr   <= stk_data_in;
            end
            if (stk_read_en) rd_pulses <= rd_pulses + 1;
            check("strobe_excl", {31'd0, stk_write_en & stk_read_en}, 32'd0);
            if (!stk_write_en) check("data_in_idle", stk_data_in, 32'd0);
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_count"}, {27'd0, count}, model_q.size());
        check({tag, "_full"},  {31'd0, full},  {31'd0, model_q.size() == DP});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, model_q.size() == 0});
    endtask

    // One complete transaction; hold = cycles resp_ready stays low once the response is up.
    task automatic xact(input logic op, input logic [DW-1:0] addr, input int hold);
        logic [DW-1:0] exp_addr;
        logic          exp_err;
        int            exp_lat, exp_wr, exp_rd, wr0, rd0, lat;
        if (op && model_q.size() < DP) begin
            model_q.push_back(addr);
            exp_addr = addr; exp_err = 1'b0; exp_lat = 2; exp_wr = 1; exp_rd = 0;
        end else if (!op && model_q.size() > 0) begin
            exp_addr = model_q.pop_back();
            exp_err = 1'b0; exp_lat = 3; exp_wr = 0; exp_rd = 1;
        end else begin
            exp_addr = '0; exp_err = 1'b1; exp_lat = 1; exp_wr = 0; exp_rd = 0;
        end
        lat = 0;
        while (!bus.req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        wr0 = wr_pulses;
        rd0 = rd_pulses;
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.resp_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 10);
        check("latency", lat, exp_lat);
        check("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("resp_addr", bus.resp_addr, exp_addr);
        check("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err});
        check("wr_pulses", wr_pulses - wr0, exp_wr);
        check("rd_pulses", rd_pulses - rd0, exp_rd);
        if (exp_wr == 1) check("push_data", last_wr, addr);
        check_flags("post");
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_addr", bus.resp_addr, exp_addr);
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_op    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("after_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("after_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("no_extra_wr", wr_pulses - wr0, exp_wr);
        check("no_extra_rd", rd_pulses - rd0, exp_rd);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;
        stk_clear      = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_addr", bus.resp_addr, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_stk", {stk_data_in[29:0], stk_write_en, stk_read_en}, 32'd0);
        rst_n     = 1'b1;
        stk_clear = 1'b0;
        @(negedge clk);

        // Underflow straight out of reset, then a simple CALL/RET round trip.
        xact(1'b0, 32'h0000_0000, 0);
        xact(1'b1, 32'h0000_1000, 0);
        xact(1'b0, 32'h0000_0000, 0);

        // LIFO ordering.
        xact(1'b1, 32'h10, 0);
        xact(1'b1, 32'h20, 0);
        xact(1'b1, 32'h30, 0);
        repeat (3) xact(1'b0, 32'h0, 0);

        // Fill to capacity, then overflow.
        for (int i = 0; i < DP; i++) xact(1'b1, 32'h100 + i, 0);
        xact(1'b1, 32'h0000_0BAD, 0);
        for (int i = 0; i < DP; i++) xact(1'b0, 32'h0, 0);

        // Response back-pressure.
        xact(1'b1, 32'hCAFE_0001, 5);
        xact(1'b0, 32'h0, 3);

        // Randomized traffic with phases biased towards filling and draining.
        for (int i = 0; i < 160; i++) begin
            int p;
            p = ((i / 40) % 2 == 0) ? 75 : 25;
            xact(1'($urandom_range(0, 99) < p), $urandom(),
                 ($urandom_range(0, 3) == 3) ? $urandom_range(1, 3) : 0);
        end

        // Reset asserted during the pop cycle.
        if (model_q.size() == 0) xact(1'b1, 32'h0000_5555, 0);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pop_strobe", {31'd0, stk_read_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_rd", {31'd0, stk_read_en}, 32'd0);
        check("rst_drop_valid", {31'd0, bus.resp_valid}, 32'd0);
        stk_clear = 1'b1;
        model_q.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        stk_clear = 1'b0;
        @(negedge clk);
        check_flags("rel");
        check("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rel_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        xact(1'b1, 32'h0000_2222, 0);
        xact(1'b0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/call_ret_unit.md
# call_ret_unit

Initiator-side controller for the 16-entry, 32-bit hardware return-address stack. Accepts CALL and RET requests from the processor control path over a valid/ready handshake. Converts each request into exactly one single-cycle push or pop strobe on the stack's `write_en`/`read_en` port, then returns the result over a response handshake. Keeps a shadow occupancy count so overflow and underflow are caught before the stack is touched; the stack silently ignores such requests.

## Interface
- `DATA_W`, default 32: return-address width; must equal stack data width.
- `DEPTH`, default 16: stack entries; must equal stack `DEPTH`.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request (high only in IDLE).
- `req_op`  in  1: 1 = CALL (push), 0 = RET (pop).
- `req_addr`  in  DATA_W: return address to push; ignored for RET.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_addr`  out  DATA_W: popped address (RET), echoed push address (CALL), 0 on error.
- `resp_err`  out  1: request rejected (overflow on CALL, underflow on RET).
- `stk_write_en`  out  1: stack push strobe.
- `stk_read_en`  out  1: stack pop strobe.
- `stk_data_in`  out  DATA_W: push data to stack.
- `stk_data_out`  in  DATA_W: stack read data, registered in the stack.
- `count`  out  $clog2(DEPTH+1): shadow occupancy, 0..DEPTH.
- `full`, `empty`  out  1 each: `count==DEPTH`, `count==0`.

## Operation
- FSM states: IDLE, PUSH, POP, CAPT, RESP.
- IDLE: `req_ready=1`. On `req_valid`, the request is latched into `op_q`/`addr_q`, and the next state is chosen as follows:
  - CALL with `count<DEPTH` → PUSH.
  - RET with `count>0` → POP.
  - Otherwise → RESP with `err_q=1` and `resp_addr=0`; no strobe is issued and `count` is unchanged.
- PUSH: `stk_write_en=1` and `stk_data_in=addr_q` for exactly this cycle. `count` increments at the edge. Next state RESP with `resp_addr=addr_q`.
- POP: `stk_read_en=1` for exactly this cycle. `count` decrements at the edge. Next state CAPT.
- CAPT: no strobes. `resp_addr` is loaded from `stk_data_out` at the edge. Next state RESP.
- RESP: `resp_valid=1`, with `resp_addr`/`resp_err` held stable. On `resp_ready` → IDLE.
- `stk_write_en` and `stk_read_en` are never both high; both are low outside PUSH/POP.
- `stk_data_in` is 0 when not in PUSH.
- `count` arithmetic saturates by construction: it can never exceed DEPTH or go below 0.

## Timing
- Reset values: state IDLE, `count=0`, `full=0`, `empty=1`, `req_ready=1`, `resp_valid=0`, `resp_addr=0`, `resp_err=0`, all `stk_*` outputs 0.
- Reset asserted mid-operation: strobes drop immediately (asynchronously) and any in-flight transaction is discarded.
  - The stack's pointer has no reset, so the top level must release `rst_n` only while the stack is at power-up state.
- CALL latency: acceptance edge E0 → PUSH cycle → `resp_valid` high after E1 (2 cycles).
- RET latency: E0 → POP → CAPT → `resp_valid` high after E2 (3 cycles).
- Error latency: `resp_valid` high after E0 (1 cycle).
- Back-to-back requests: a new request is accepted in the first IDLE cycle after the response handshake. Throughput is at most one request per 3 (CALL) or 4 (RET) cycles with `resp_ready` tied high.
- `resp_ready` low: the unit stays in RESP indefinitely and `req_ready` stays 0.
- `req_valid` outside IDLE is ignored, since `req_ready=0`.

## Structure
- Shared package `ras_pkg`:
  - `op_e` (OP_RET=0, OP_CALL=1).
  - `state_e` for the five states.
  - `RAS_DEPTH=16`, `RAS_DATA_W=32`.
- One natural sub-module, `ras_occupancy`: an up/down counter with `inc`/`dec` inputs and `count`/`full`/`empty` outputs, reset via `rst_n`.
- The FSM and datapath registers live in `call_ret_unit`.

## Test plan
- CALL 0x0000_1000 then RET, with the stack model attached → one `stk_write_en` pulse carrying 0x1000, then one `stk_read_en` pulse. RET response has `resp_addr=0x1000`, `resp_err=0`, and `count` goes 0→1→0.
- CALL 0x10, 0x20, 0x30, then 3× RET → `resp_addr` 0x30, 0x20, 0x10 in that order (LIFO), with `count` back at 0.
- 16 CALLs (0x100..0x10F), then a 17th CALL → `full=1`. The 17th responds `resp_err=1`, `resp_addr=0`, no `stk_write_en` pulse, `count` stays 16.
- RET out of reset → `resp_err=1` after 1 cycle, no `stk_read_en`, `empty` stays 1.
- CALL with `resp_ready` held low for 5 cycles → `resp_valid` and `resp_addr` stay stable and `req_ready=0` throughout. IDLE resumes the cycle after `resp_ready` rises.
- Deassert `rst_n` during a POP cycle → `stk_read_en` falls immediately, and `count=0`, `resp_valid=0` with `req_ready=1` after reset release.
